// File: rtl/glyph_row_renderer.sv
// Renders a row of NUM_GLYPHS monochrome bitmaps into a VGA adapter pixel-write port, one pixel per clk,
// after a power-on clear sweep. Optional macro OPAQUE_GLYPH_EN: opaque draw, erase skipped on same origin.
// Handshake: a request is accepted on the rising clk edge where req_valid && req_ready; req_ready is
// high only while idle, and req_valid while busy is dropped (never queued).
module glyph_row_renderer #(
  parameter int NUM_GLYPHS = 3,
  parameter int GLYPH_W    = 12,
  parameter int GLYPH_H    = 12,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [X_W-1:0]                          x,
  input  logic [Y_W-1:0]                          y,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0]   glyph_bits,
  input  logic [COLOUR_W-1:0]                     colour_in,
  output logic [X_W-1:0]                          x_out,
  output logic [Y_W-1:0]                          y_out,
  output logic [COLOUR_W-1:0]                     colour,
  output logic                                    writeEn,
  output logic                                    busy,
  output logic                                    done,
  output logic [2:0]                              o_dbg_state
);

  localparam int NB  = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int XS  = X_W + 1;
  localparam int YS  = Y_W + 1;
  localparam int CW  = $clog2(GLYPH_W + 1);
  localparam int RW  = $clog2(GLYPH_H + 1);
  localparam int KW  = $clog2(NUM_GLYPHS + 1);
  localparam int KXW = $clog2(NUM_GLYPHS * GLYPH_W + 1);

  localparam logic [CW-1:0]  C_LAST  = CW'(GLYPH_W - 1);
  localparam logic [RW-1:0]  R_LAST  = RW'(GLYPH_H - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(NUM_GLYPHS - 1);
  localparam logic [KXW-1:0] KX_STEP = KXW'(GLYPH_W);
  localparam logic [X_W-1:0] X_LAST  = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(SCREEN_H - 1);
  localparam logic [XS-1:0]  SCR_W   = XS'(SCREEN_W);
  localparam logic [YS-1:0]  SCR_H   = YS'(SCREEN_H);

  localparam logic [2:0] S_SWEEP = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ERASE = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [X_W-1:0]      r_sx;
  logic [Y_W-1:0]      r_sy;
  logic [CW-1:0]       r_c;
  logic [RW-1:0]       r_r;
  logic [KW-1:0]       r_k;
  logic [KXW-1:0]      r_kx;
  logic [NB-1:0]       r_bits;
  logic [X_W-1:0]      r_ox, r_prev_x;
  logic [Y_W-1:0]      r_oy, r_prev_y;
  logic [COLOUR_W-1:0] r_col;
  logic                r_prev_valid;

  logic [X_W-1:0]      r_x_out;
  logic [Y_W-1:0]      r_y_out;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_we, r_done, r_ready, r_busy;

  logic [2:0]          w_state_nxt;
  logic                w_accept, w_last_pix, w_sweep_last, w_skip_erase;
  logic [X_W-1:0]      w_base_x;
  logic [Y_W-1:0]      w_base_y;
  logic [XS-1:0]       w_px;
  logic [YS-1:0]       w_py;
  logic                w_in_scr, w_bit, w_pix_cyc, w_pen;
  logic [X_W-1:0]      w_pix_x;
  logic [Y_W-1:0]      w_pix_y;
  logic [COLOUR_W-1:0] w_pcol;

  assign w_accept     = req_valid && r_ready && (r_state == S_IDLE);
  assign w_last_pix   = (r_c == C_LAST) && (r_r == R_LAST) && (r_k == K_LAST);
  assign w_sweep_last = (r_sx == X_LAST) && (r_sy == Y_LAST);
`ifdef OPAQUE_GLYPH_EN
  // An opaque redraw at the same origin overwrites every box pixel, so erasing first is redundant.
  assign w_skip_erase = (x == r_prev_x) && (y == r_prev_y);
`else
  assign w_skip_erase = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SWEEP: if (w_sweep_last) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_accept) w_state_nxt = (r_prev_valid && !w_skip_erase) ? S_ERASE : S_DRAW;
      S_ERASE: if (w_last_pix) w_state_nxt = S_DRAW;
      S_DRAW:  if (w_last_pix) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_SWEEP;
    endcase
  end

  // Pixel addressed by the counters this cycle; registered onto the adapter port next cycle.
  always_comb begin
    w_base_x  = (r_state == S_ERASE) ? r_prev_x : r_ox;
    w_base_y  = (r_state == S_ERASE) ? r_prev_y : r_oy;
    w_px      = XS'(w_base_x) + XS'(r_kx) + XS'(r_c);
    w_py      = YS'(w_base_y) + YS'(r_r);
    w_in_scr  = (w_px < SCR_W) && (w_py < SCR_H);
    w_bit     = r_bits[NB-1];
    w_pix_x   = w_px[X_W-1:0];
    w_pix_y   = w_py[Y_W-1:0];
    w_pix_cyc = 1'b0;
    w_pen     = 1'b0;
    w_pcol    = '0;
    case (r_state)
      S_SWEEP: begin
        w_pix_cyc = 1'b1;
        w_pen     = 1'b1;
        w_pix_x   = r_sx;
        w_pix_y   = r_sy;
      end
      S_ERASE: begin
        w_pix_cyc = 1'b1;
        w_pen     = w_in_scr;
      end
      S_DRAW: begin
        w_pix_cyc = 1'b1;
`ifdef OPAQUE_GLYPH_EN
        w_pen     = w_in_scr;
        w_pcol    = w_bit ? r_col : '0;
`else
        w_pen     = w_bit && w_in_scr;
        w_pcol    = r_col;
`endif
      end
      default: w_pix_cyc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_SWEEP;
      r_sx         <= '0;
      r_sy         <= '0;
      r_c          <= '0;
      r_r          <= '0;
      r_k          <= '0;
      r_kx         <= '0;
      r_bits       <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_col        <= '0;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_SWEEP: begin
          if (r_sx == X_LAST) begin
            r_sx <= '0;
            r_sy <= (r_sy == Y_LAST) ? '0 : r_sy + Y_W'(1);
          end else begin
            r_sx <= r_sx + X_W'(1);
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_ox   <= x;
            r_oy   <= y;
            r_bits <= glyph_bits;
            r_col  <= colour_in;
            r_c    <= '0;
            r_r    <= '0;
            r_k    <= '0;
            r_kx   <= '0;
          end
        end
        S_ERASE, S_DRAW: begin
          // The bitmap shifts only while drawing, so its MSB always tracks the current draw pixel.
          if (r_state == S_DRAW) r_bits <= r_bits << 1;
          if (r_c != C_LAST) begin
            r_c <= r_c + CW'(1);
          end else begin
            r_c <= '0;
            if (r_r != R_LAST) begin
              r_r <= r_r + RW'(1);
            end else begin
              r_r <= '0;
              if (r_k != K_LAST) begin
                r_k  <= r_k + KW'(1);
                r_kx <= r_kx + KX_STEP;
              end else begin
                r_k  <= '0;
                r_kx <= '0;
                if (r_state == S_DRAW) begin
                  r_prev_x     <= r_ox;
                  r_prev_y     <= r_oy;
                  r_prev_valid <= 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Ready/busy are registered from the next state, so the first S_IDLE cycle (done pulse) still reads busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x_out  <= '0;
      r_y_out  <= '0;
      r_colour <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_we   <= w_pen;
      r_done <= (r_state == S_DONE);
      r_ready <= (r_state == S_IDLE) && (w_state_nxt == S_IDLE);
      r_busy  <= !((r_state == S_IDLE) && (w_state_nxt == S_IDLE));
      if (w_pix_cyc) begin
        r_x_out  <= w_pix_x;
        r_y_out  <= w_pix_y;
        r_colour <= w_pcol;
      end
    end
  end

  assign x_out       = r_x_out;
  assign y_out       = r_y_out;
  assign colour      = r_colour;
  assign writeEn     = r_we;
  assign done        = r_done;
  assign req_ready   = r_ready;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_glyph_row_renderer.sv
// Bench for glyph_row_renderer: table vectors, hand-written reset/busy sequences and random requests
// checked against a pixel-list reference model built from the scan rules.
module tb_glyph_row_renderer;

  localparam int NG = 3;
  localparam int GW = 12;
  localparam int GH = 12;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int NB = NG * GW * GH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    x = '0;
  logic [6:0]    y = '0;
  logic [NB-1:0] glyph_bits = '0;
  logic [2:0]    colour_in = '0;
  logic [7:0]    x_out;
  logic [6:0]    y_out;
  logic [2:0]    colour;
  logic          writeEn, busy, done;
  logic [2:0]    dbg_state;

  glyph_row_renderer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .x(x), .y(y), .glyph_bits(glyph_bits), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn),
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: previous origin and one {we, x, y, colour} entry per pixel cycle.
  int          m_prev_x, m_prev_y;
  bit          m_prev_valid = 1'b0;
  logic [18:0] exp_q[$];

  typedef struct {
    int x, y, pat, col;
    bit poke;
    int exp_total, exp_erase_we, exp_draw_we, exp_min_x, exp_max_x;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_s(input string name, input int act, input int req, input string info);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (%s)", name, act, req, info);
    end
  endtask

  function automatic logic [NB-1:0] make_bits(input int pat);
    logic [NB-1:0] b;
    int p, q;
    b = '0;
    for (int i = 0; i < NB; i++) begin
      p = NB - 1 - i;
      q = p % (GW * GH);
      case (pat)
        0: b[i] = (p < GW * GH);
        1: b[i] = 1'b1;
        2: b[i] = (p >= GW * GH) && (p < 2 * GW * GH);
        default: b[i] = (((q / GW) + (q % GW)) % 2) == 0;
      endcase
    end
    return b;
  endfunction

  task automatic model_req(input int ox, input int oy, input logic [NB-1:0] b, input logic [2:0] c,
                           output int n_erase);
    bit do_erase;
    int px, py, idx;
    bit on, bv, we;
    logic [2:0] pc;
    exp_q.delete();
    n_erase = 0;
    do_erase = m_prev_valid;
`ifdef OPAQUE_GLYPH_EN
    if (ox == m_prev_x && oy == m_prev_y) do_erase = 1'b0;
`endif
    if (do_erase) begin
      for (int k = 0; k < NG; k++)
        for (int r = 0; r < GH; r++)
          for (int cc = 0; cc < GW; cc++) begin
            px = m_prev_x + k * GW + cc;
            py = m_prev_y + r;
            on = (px < SW) && (py < SH);
            exp_q.push_back({on, 8'(px), 7'(py), 3'd0});
            n_erase++;
          end
    end
    for (int k = 0; k < NG; k++)
      for (int r = 0; r < GH; r++)
        for (int cc = 0; cc < GW; cc++) begin
          px  = ox + k * GW + cc;
          py  = oy + r;
          on  = (px < SW) && (py < SH);
          idx = (NG - k) * GW * GH - 1 - (r * GW + cc);
          bv  = b[idx];
`ifdef OPAQUE_GLYPH_EN
          we = on;
          pc = bv ? c : 3'd0;
`else
          we = on && bv;
          pc = c;
`endif
          exp_q.push_back({we, 8'(px), 7'(py), pc});
        end
    m_prev_x = ox;
    m_prev_y = oy;
    m_prev_valid = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_out"}, int'(x_out), 0);
    check({tag, "_y_out"}, int'(y_out), 0);
    check({tag, "_colour"}, int'(colour), 0);
    check({tag, "_writeEn"}, int'(writeEn), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  // Caller releases reset at a negedge; the first pixel of the sweep is visible at the next negedge.
  task automatic sweep_check();
    int errs, stray, wait_n;
    string first;
    errs = 0;
    stray = 0;
    first = "";
    for (int i = 0; i < SW * SH; i++) begin
      @(negedge clk);
      if (!(writeEn === 1'b1 && x_out === 8'(i % SW) && y_out === 7'(i / SW) && colour === 3'd0)) begin
        if (errs == 0)
          first = $sformatf("pixel %0d got we=%0b x=%0d y=%0d c=%0d required we=1 x=%0d y=%0d c=0",
                            i, writeEn, x_out, y_out, colour, i % SW, i / SW);
        errs++;
      end
    end
    check_s("sweep_stream", errs, 0, first);
    wait_n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && wait_n < 5) begin
      if (writeEn !== 1'b0) stray++;
      @(negedge clk);
      wait_n++;
    end
    if (writeEn !== 1'b0) stray++;
    check("sweep_ready", int'(req_ready), 1);
    check("sweep_stray_we", stray, 0);
  endtask

  task automatic run_req(input int rx, input int ry, input logic [NB-1:0] rb, input logic [2:0] rc,
                         input bit poke, output int total, output int e_we, output int d_we,
                         output int mnx, output int mxx);
    int n_erase, errs, wait_n, done_i, stray;
    logic [18:0] e;
    string first;
    model_req(rx, ry, rb, rc, n_erase);
    wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("req_ready_wait", int'(req_ready), 1);
    x = 8'(rx);
    y = 7'(ry);
    glyph_bits = rb;
    colour_in = rc;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("accept_gap_we", int'(writeEn), 0);
    check("busy_in_req", int'(busy), 1);
    errs = 0;
    first = "";
    done_i = -1;
    e_we = 0;
    d_we = 0;
    mnx = 9999;
    mxx = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (poke && i == 100) begin
        req_valid = 1'b1;
        x = 8'd77;
        y = 7'd7;
        colour_in = 3'd1;
      end
      if (poke && i == 101) req_valid = 1'b0;
      if (done === 1'b1) begin
        done_i = i;
        if (writeEn !== 1'b0) begin
          if (errs == 0) first = $sformatf("writeEn high in done cycle %0d", i);
          errs++;
        end
        break;
      end
      if (i >= exp_q.size()) begin
        if (errs == 0) first = $sformatf("cycle %0d past end of expected stream", i);
        errs++;
      end else begin
        e = exp_q[i];
        if ((e[18] && {writeEn, x_out, y_out, colour} !== e) || (!e[18] && writeEn !== 1'b0)) begin
          if (errs == 0)
            first = $sformatf("cycle %0d got we=%0b x=%0d y=%0d c=%0d required we=%0b x=%0d y=%0d c=%0d",
                              i, writeEn, x_out, y_out, colour, e[18], e[17:10], e[9:3], e[2:0]);
          errs++;
        end
      end
      if (writeEn === 1'b1) begin
        if (i < n_erase) e_we++;
        else begin
          d_we++;
          if (int'(x_out) < mnx) mnx = int'(x_out);
          if (int'(x_out) > mxx) mxx = int'(x_out);
        end
      end
    end
    check_s("req_stream", errs, 0, first);
    check("done_timing", done_i, exp_q.size());
    total = done_i;
    @(negedge clk);
    check("done_single", int'(done), 0);
    check("ready_after_done", int'(req_ready), 1);
    if (poke) begin
      stray = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (writeEn !== 1'b0 || busy !== 1'b0) stray++;
      end
      check("busy_req_not_queued", stray, 0);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total, e_we, d_we, mnx, mxx, rx, ry, rc;
    logic [NB-1:0] rb;

`ifdef OPAQUE_GLYPH_EN
    tbl[0] = '{10, 20, 0, 5, 1'b0, 432, 0, 432, 10, 45};
    tbl[1] = '{40, 50, 0, 3, 1'b1, 864, 432, 432, 40, 75};
    tbl[2] = '{150, 115, 1, 7, 1'b0, 864, 432, 50, 150, 159};
    tbl[3] = '{0, 0, 2, 2, 1'b0, 864, 50, 432, 0, 35};
`else
    tbl[0] = '{10, 20, 0, 5, 1'b0, 432, 0, 144, 10, 21};
    tbl[1] = '{40, 50, 0, 3, 1'b1, 864, 432, 144, 40, 51};
    tbl[2] = '{150, 115, 1, 7, 1'b0, 864, 432, 50, 150, 159};
    tbl[3] = '{0, 0, 2, 2, 1'b0, 864, 50, 144, 12, 23};
`endif

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    sweep_check();

    for (int i = 0; i < 4; i++) begin
      run_req(tbl[i].x, tbl[i].y, make_bits(tbl[i].pat), 3'(tbl[i].col), tbl[i].poke,
              total, e_we, d_we, mnx, mxx);
      check($sformatf("vec%0d_total", i), total, tbl[i].exp_total);
      check($sformatf("vec%0d_erase_we", i), e_we, tbl[i].exp_erase_we);
      check($sformatf("vec%0d_draw_we", i), d_we, tbl[i].exp_draw_we);
      check($sformatf("vec%0d_min_x", i), mnx, tbl[i].exp_min_x);
      check($sformatf("vec%0d_max_x", i), mxx, tbl[i].exp_max_x);
    end

    // Reset asserted between clock edges in the middle of a draw.
    x = 8'd60;
    y = 7'd60;
    glyph_bits = make_bits(1);
    colour_in = 3'd6;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (60) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    m_prev_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sweep_check();
    run_req(30, 30, make_bits(0), 3'd4, 1'b0, total, e_we, d_we, mnx, mxx);
    check("post_reset_total", total, 432);
    check("post_reset_erase_we", e_we, 0);

    for (int t = 0; t < 6; t++) begin
      if (t != 3) begin
        rx = $urandom_range(0, 255);
        ry = $urandom_range(0, 127);
      end
      for (int j = 0; j < NB; j++) rb[j] = 1'($urandom_range(0, 1));
      rc = $urandom_range(0, 7);
      run_req(rx, ry, rb, 3'(rc), 1'b0, total, e_we, d_we, mnx, mxx);
    end

`ifdef OPAQUE_GLYPH_EN
    run_req(20, 20, make_bits(3), 3'd5, 1'b0, total, e_we, d_we, mnx, mxx);
    run_req(20, 20, make_bits(3), 3'd5, 1'b0, total, e_we, d_we, mnx, mxx);
    check("opaque_same_total", total, 432);
    check("opaque_same_erase_we", e_we, 0);
    check("opaque_same_draw_we", d_we, 432);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
